// File: rtl/i2s_rx.sv
// 24-bit stereo I2S receiver: oversamples bck/lrck/adata in the scki domain,
// deserializes MSB-first channel words and hands out left/right pairs via valid/ready.
module i2s_rx #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             scki,
  input  logic             rst,
  input  logic             bck,
  input  logic             lrck,
  input  logic             adata,
  input  logic             sample_ready,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             sample_valid,
  output logic             overrun,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAD
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_bck_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic [SYNC_STAGES-1:0] r_adata_sync;
  logic                   r_bck_d;
  logic                   r_lrck_prev;
  logic                   r_chan;
  logic                   r_left_held;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_shreg;
  logic [WIDTH-1:0]       r_left_hold;
  logic [WIDTH-1:0]       r_left_data;
  logic [WIDTH-1:0]       r_right_data;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   r_frame_err;

  logic                   w_bck;
  logic                   w_lrck;
  logic                   w_adata;
  logic                   w_bck_rise;
  logic                   w_ws_edge;
  logic                   w_word_done;
  logic                   w_pair_done;
  logic [WIDTH-1:0]       w_word;

  assign w_bck      = r_bck_sync[SYNC_STAGES-1];
  assign w_lrck     = r_lrck_sync[SYNC_STAGES-1];
  assign w_adata    = r_adata_sync[SYNC_STAGES-1];
  assign w_bck_rise = w_bck & ~r_bck_d;
  assign w_ws_edge  = w_bck_rise & (w_lrck != r_lrck_prev);
  assign w_word     = {r_shreg[WIDTH-2:0], w_adata};

  // Last data bit of a channel: completes a word; a right word completes a pair
  // only when a left word is being held.
  assign w_word_done = (r_state == SHIFT) && w_bck_rise && !w_ws_edge &&
                       (r_cnt == CW'(WIDTH - 1));
  assign w_pair_done = w_word_done && r_chan && r_left_held;

  always_ff @(posedge scki) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bck_sync   <= '0;
      r_lrck_sync  <= '0;
      r_adata_sync <= '0;
      r_bck_d      <= 1'b0;
      r_lrck_prev  <= 1'b0;
      r_chan       <= 1'b0;
      r_left_held  <= 1'b0;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_left_hold  <= '0;
      r_left_data  <= '0;
      r_right_data <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_bck_sync   <= {r_bck_sync[SYNC_STAGES-2:0], bck};
      r_lrck_sync  <= {r_lrck_sync[SYNC_STAGES-2:0], lrck};
      r_adata_sync <= {r_adata_sync[SYNC_STAGES-2:0], adata};
      r_bck_d      <= w_bck;
      r_frame_err  <= 1'b0;

      if (w_bck_rise) begin
        r_lrck_prev <= w_lrck;
        case (r_state)
          IDLE, PAD: begin
            if (w_ws_edge) begin
              r_state <= SHIFT;
              r_cnt   <= '0;
              r_chan  <= w_lrck;
            end
          end
          SHIFT: begin
            if (w_ws_edge) begin
              r_frame_err <= 1'b1;
              r_left_held <= 1'b0;
              r_cnt       <= '0;
              r_chan      <= w_lrck;
            end else begin
              r_shreg <= w_word;
              r_cnt   <= r_cnt + 1'b1;
              if (w_word_done) begin
                r_state <= PAD;
                if (!r_chan) begin
                  r_left_hold <= w_word;
                  r_left_held <= 1'b1;
                end else begin
                  r_left_held <= 1'b0;
                end
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end

      // A load in the same cycle as an accept keeps valid high.
      if (w_pair_done) begin
        if (!r_valid || sample_ready) begin
          r_left_data  <= r_left_hold;
          r_right_data <= w_word;
          r_valid      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign left_data    = r_left_data;
  assign right_data   = r_right_data;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: table-driven frames, randomized frames against a slot-level
// framing model, and hand-written backpressure / reset corner cases.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int unsigned W = 24;

  logic         scki = 1'b0;
  logic         rst = 1'b1;
  logic         bck = 1'b0;
  logic         lrck = 1'b0;
  logic         adata = 1'b0;
  logic         sample_ready = 1'b0;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         sample_valid;
  logic         overrun;
  logic         frame_err;

  i2s_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .scki        (scki),
    .rst         (rst),
    .bck         (bck),
    .lrck        (lrck),
    .adata       (adata),
    .sample_ready(sample_ready),
    .left_data   (left_data),
    .right_data  (right_data),
    .sample_valid(sample_valid),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  always #5 scki = ~scki;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Framing model: works on whole slots, not on bck rises.
  bit          m_prev;
  bit          m_partial;
  bit          m_has_left;
  logic [W-1:0] m_left;
  int          m_ferr_exp = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic model_reset();
    m_prev     = 1'b0;
    m_partial  = 1'b0;
    m_has_left = 1'b0;
  endtask

  task automatic model_slot(input bit ch, input logic [W-1:0] w, input int nbits);
    if (ch != m_prev) begin
      if (m_partial) begin
        m_ferr_exp++;
        m_has_left = 1'b0;
      end
      m_prev = ch;
      if (nbits >= W) begin
        m_partial = 1'b0;
        if (!ch) begin
          m_left     = w;
          m_has_left = 1'b1;
        end else if (m_has_left) begin
          exp_q.push_back({m_left, w});
          m_has_left = 1'b0;
        end
      end else begin
        m_partial = 1'b1;
      end
    end
  endtask

  // Monitor: samples on the falling scki edge, inputs change at posedge+2.
  int n_acc  = 0;
  int n_ferr = 0;
  bit ferr_prev = 1'b0;

  always @(negedge scki) begin
    if (!rst) begin
      if (frame_err) begin
        n_ferr++;
        check("frame_err_width", {63'd0, ferr_prev}, 64'd0);
      end
      if (sample_valid && sample_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pair: got %0h expected none", {left_data, right_data});
        end else begin
          check("pair", {16'd0, left_data, right_data}, {16'd0, exp_q.pop_front()});
        end
      end
    end
    ferr_prev = frame_err;
  end

  task automatic tick();
    @(posedge scki);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_left"},    {40'd0, left_data},  64'd0);
    check({tag, "_right"},   {40'd0, right_data}, 64'd0);
    check({tag, "_valid"},   {63'd0, sample_valid}, 64'd0);
    check({tag, "_overrun"}, {63'd0, overrun},    64'd0);
    check({tag, "_ferr"},    {63'd0, frame_err},  64'd0);
  endtask

  // One bck period (4 scki cycles); optional ready pulse timed onto the cycle in
  // which this rise is processed, optional one-cycle rst during the high phase.
  task automatic drive_rise(input bit lr, input bit d, input bit pulse, input bit rst_here);
    bck = 1'b0; lrck = lr; adata = d;
    tick(); tick();
    bck = 1'b1;
    if (rst_here) rst = 1'b1;
    tick();
    if (rst_here) begin
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
    end
    tick();
    if (pulse) begin
      bck = 1'b0;
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
    end
  endtask

  task automatic send_slot(input bit ch, input logic [W-1:0] word, input int nbits,
                           input int pad, input bit pulse, input int rst_at);
    bit d;
    model_slot(ch, word, nbits);
    for (int i = 0; i < 1 + nbits + pad; i++) begin
      if (i >= 1 && i <= nbits) d = word[W-i];
      else d = 1'($urandom_range(0, 1));
      drive_rise(ch, d, pulse && (i == W), i == rst_at);
    end
    if (rst_at >= 0) model_reset();
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                            input int lbits, input int pad);
    send_slot(1'b0, l, lbits, (lbits == W) ? pad : 0, 1'b0, -1);
    send_slot(1'b1, r, W, pad, 1'b0, -1);
  endtask

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           lbits;
    int           exp_pairs;
    int           exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int f0;
    vecs[0] = '{24'h7FFFFF, 24'h800000, 24, 1, 0};
    vecs[1] = '{24'h7FFFFF, 24'h800000, 24, 1, 0};
    vecs[2] = '{24'hABCDEF, 24'h012345, 11, 0, 1};
    vecs[3] = '{24'h123456, 24'h654321, 24, 1, 0};
    vecs[4] = '{24'h000000, 24'hFFFFFF, 24, 1, 0};
    vecs[5] = '{24'hFFFFFF, 24'h000000, 24, 1, 0};
    vecs[6] = '{24'h800001, 24'h7FFFFE, 24, 1, 0};

    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    sample_ready = 1'b1;

    // First lrck edge after reset lands on a right slot: consumed, no pair.
    send_slot(1'b1, W'($urandom), W, 7, 1'b0, -1);
    check("sync_no_pair", n_acc, 0);

    foreach (vecs[k]) begin
      a0 = n_acc;
      f0 = n_ferr;
      send_frame(vecs[k].l, vecs[k].r, vecs[k].lbits, 7);
      check($sformatf("vec%0d_pairs", k), n_acc - a0, vecs[k].exp_pairs);
      check($sformatf("vec%0d_ferr", k), n_ferr - f0, vecs[k].exp_ferr);
      check($sformatf("vec%0d_overrun", k), {63'd0, overrun}, 64'd0);
      if (vecs[k].exp_pairs == 1) begin
        check($sformatf("vec%0d_left", k), {40'd0, left_data}, {40'd0, vecs[k].l});
        check($sformatf("vec%0d_right", k), {40'd0, right_data}, {40'd0, vecs[k].r});
      end
    end

    a0 = n_acc;
    for (int k = 0; k < 20; k++)
      send_frame(W'($urandom), W'($urandom), W, $urandom_range(0, 7));
    check("random_pairs", n_acc - a0, 20);

    // Accept of the held pair coincides with completion of the next one.
    sample_ready = 1'b0;
    a0 = n_acc;
    send_frame(24'hA5A5A5, 24'h5A5A5A, W, 7);
    check("same_valid0", {63'd0, sample_valid}, 64'd1);
    send_slot(1'b0, 24'h111111, W, 7, 1'b0, -1);
    send_slot(1'b1, 24'h222222, W, 7, 1'b1, -1);
    check("same_acc", n_acc - a0, 1);
    check("same_valid1", {63'd0, sample_valid}, 64'd1);
    check("same_left", {40'd0, left_data}, 64'h111111);
    check("same_right", {40'd0, right_data}, 64'h222222);
    check("same_overrun", {63'd0, overrun}, 64'd0);
    sample_ready = 1'b1;
    repeat (4) tick();
    check("same_drain", n_acc - a0, 2);

    // Backpressure across two frames: second pair dropped, overrun sticky.
    sample_ready = 1'b0;
    a0 = n_acc;
    send_frame(24'h000001, 24'h000002, W, 7);
    send_frame(24'h000003, 24'h000004, W, 7);
    void'(exp_q.pop_back());
    check("bp_left", {40'd0, left_data}, 64'h1);
    check("bp_right", {40'd0, right_data}, 64'h2);
    check("bp_valid", {63'd0, sample_valid}, 64'd1);
    check("bp_overrun", {63'd0, overrun}, 64'd1);
    sample_ready = 1'b1;
    repeat (4) tick();
    check("bp_acc", n_acc - a0, 1);
    check("bp_valid_clr", {63'd0, sample_valid}, 64'd0);
    check("bp_overrun_sticky", {63'd0, overrun}, 64'd1);

    // Reset in the middle of a left word; resync needs a fresh lrck edge.
    a0 = n_acc;
    send_slot(1'b0, W'($urandom), W, 7, 1'b0, 10);
    send_slot(1'b1, W'($urandom), W, 7, 1'b0, -1);
    check("midrst_no_pair", n_acc - a0, 0);
    send_frame(24'hC0FFEE, 24'h0BEEF0, W, 7);
    check("midrst_pair", n_acc - a0, 1);
    check("midrst_left", {40'd0, left_data}, 64'hC0FFEE);
    check("midrst_right", {40'd0, right_data}, 64'h0BEEF0);

    repeat (8) tick();
    check("queue_empty", exp_q.size(), 0);
    check("ferr_total", n_ferr, m_ferr_exp);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
